pll_ctrl_seq: RTL
=================

Name: pll_ctrl_seq

Overview:
Power-up and recovery sequencer for the iCE40 two-output PLL core (SB_PLL40_2F_CORE) instance. It drives the PLL's RESETB, BYPASS and LATCHINPUTVALUE pins and monitors LOCK. It holds the downstream system in reset until the PLL clock has been stable, retries relock on timeout, and falls back to bypass after repeated failure. It runs on the PLL reference clock and sits between the board reset and the PLL instance.

Parameters:
RST_CYCLES, 16, cycles PLL_RESETB is held low per attempt (>=2)
LOCK_TIMEOUT, 1024, max cycles in WAIT_LOCK before the attempt fails (>=2)
STABLE_CYCLES, 64, consecutive synced-lock cycles required before RUN (>=2)
MAX_RETRIES, 3, failed attempts before FAIL (1..15)
CNT_W, 11, shared counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1

Ports:
REFERENCECLK  in   1  sole clock (PLL reference clock)
RESET         in   1  asynchronous, active-low reset
PLL_LOCK      in   1  PLL LOCK pin, asynchronous to REFERENCECLK
SLEEP_REQ     in   1  level request to freeze the PLL (low-power)
PLL_RESETB    out  1  to PLL RESETB, active-low
PLL_BYPASS    out  1  to PLL BYPASS
PLL_LATCH     out  1  to PLL LATCHINPUTVALUE
CLK_READY     out  1  PLL output (or bypass clock) usable
SYS_RESETN    out  1  active-low reset for downstream logic
SLEEP_ACK     out  1  PLL latched, safe to sleep
FAIL          out  1  retries exhausted, PLL in bypass
RETRY_CNT     out  4  failed attempts since last RUN
STATE         out  3  current state encoding, for debug

Behaviour:
- One clock; reset is asynchronous and active-low: the clock port is REFERENCECLK and the reset port is RESET. RESET low clears all flops immediately. Release takes effect on the next REFERENCECLK edge.
- All outputs are registered. Reset values: PLL_RESETB=0, PLL_BYPASS=0, PLL_LATCH=0, CLK_READY=0, SYS_RESETN=0, SLEEP_ACK=0, FAIL=0, RETRY_CNT=0, STATE=0 (RST_HOLD), counter=0.
- PLL_LOCK passes through a 2-flop synchronizer, reset to 0, to form lock_s. Latency is 2 cycles.
- States: RST_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, DRAIN=4, SLEEP=5, FAIL=6. Code 7 is unreachable and returns to RST_HOLD.
- The shared counter clears to 0 on every state change and increments every cycle otherwise.
- RST_HOLD:
  - PLL_RESETB=0.
  - Go to WAIT_LOCK when cnt==RST_CYCLES-1, so RST_HOLD lasts exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - PLL_RESETB=1.
  - lock_s=1 → STABLE.
  - Else, if cnt==LOCK_TIMEOUT-1 → RETRY.
- STABLE:
  - lock_s=0 → RETRY.
  - cnt==STABLE_CYCLES-1 with lock_s=1 → RUN.
  - lock_s low on that last cycle takes priority (RETRY).
- RETRY (an action, not a state):
  - RETRY_CNT += 1.
  - If the new value equals MAX_RETRIES → FAIL, else → RST_HOLD.
- RUN:
  - CLK_READY=1 and SYS_RESETN=1, both rising on the first cycle STATE=3.
  - RETRY_CNT clears to 0 on entry.
  - lock_s=0 → RST_HOLD; CLK_READY and SYS_RESETN drop with the state change. Lock loss in RUN does not count as a retry.
  - Else, SLEEP_REQ=1 → DRAIN.
  - Lock loss has priority over SLEEP_REQ in the same cycle.
- DRAIN:
  - Lasts exactly 1 cycle.
  - CLK_READY=0, SYS_RESETN=1 (logic state kept), then → SLEEP.
- SLEEP:
  - PLL_LATCH=1, SLEEP_ACK=1, CLK_READY=0, SYS_RESETN=1.
  - lock_s is ignored.
  - SLEEP_REQ=0 → WAIT_LOCK: PLL_LATCH and SLEEP_ACK drop on entry, PLL_RESETB stays 1, RETRY_CNT is unchanged.
- FAIL:
  - PLL_BYPASS=1, PLL_RESETB=0, FAIL=1, CLK_READY=1, SYS_RESETN=1 (system runs on the bypassed reference).
  - SLEEP_REQ is ignored; SLEEP_ACK=0.
  - Only RESET exits FAIL.
- SLEEP_REQ is sampled only in RUN and SLEEP. In other states it is held off, with no effect until RUN.
- PLL_BYPASS=1 only in FAIL. PLL_LATCH=1 only in SLEEP.

Test Plan:
- Bring-up: release RESET, PLL_LOCK rises at cycle 30 → PLL_RESETB rises at cycle 16; STATE goes 1→2 at about 33, RUN at about 33+64. CLK_READY and SYS_RESETN rise together with STATE=3; RETRY_CNT=0.
- Timeout: PLL_LOCK held 0 with LOCK_TIMEOUT=32 → 3 attempts of 16+32 cycles each; RETRY_CNT goes 1, 2, then FAIL=1, PLL_BYPASS=1, CLK_READY=1, STATE=6.
- Lock glitch: in STABLE, pull PLL_LOCK low for 1 cycle → RETRY_CNT=1, STATE=0, PLL_RESETB low for 16 cycles. Then hold lock → RUN and RETRY_CNT=0.
- Lock loss in RUN: drop PLL_LOCK → 3 cycles later STATE=0, CLK_READY=0, SYS_RESETN=0, RETRY_CNT unchanged (0).
- Sleep: SLEEP_REQ=1 in RUN → CLK_READY=0 next cycle, DRAIN for 1 cycle, then PLL_LATCH=1 and SLEEP_ACK=1. Drop SLEEP_REQ → WAIT_LOCK and PLL_LATCH=0; RUN again after STABLE_CYCLES. Also assert SLEEP_REQ together with lock loss → RST_HOLD wins.
- Async reset mid-operation: assert RESET low between clock edges in RUN and in FAIL → all outputs return to reset values without waiting for a clock edge; the sequence restarts cleanly.

Source files
------------

// File: rtl/pll_ctrl_seq.sv
// Power-up / recovery sequencer for an iCE40 SB_PLL40_2F_CORE: drives RESETB, BYPASS and
// LATCHINPUTVALUE, qualifies LOCK, and gates the downstream reset until the PLL clock is stable.
module pll_ctrl_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 11
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       SLEEP_REQ,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       PLL_LATCH,
    output logic       CLK_READY,
    output logic       SYS_RESETN,
    output logic       SLEEP_ACK,
    output logic       FAIL,
    output logic [3:0] RETRY_CNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SLEEP     = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic [3:0]       retry_inc;
    logic             do_retry;
    logic [1:0]       sync_reg;
    logic             lock_s;

    logic resetb_reg, resetb_next;
    logic bypass_reg, bypass_next;
    logic latch_reg, latch_next;
    logic ready_reg, ready_next;
    logic sysrstn_reg, sysrstn_next;
    logic ack_reg, ack_next;
    logic fail_reg, fail_next;

    // LOCK comes straight from the PLL analog block, so it is resynchronised before use.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], PLL_LOCK};
        end
    end

    assign lock_s    = sync_reg[1];
    assign retry_inc = retry_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        do_retry   = 1'b0;
        case (state_reg)
            ST_RST_HOLD: begin
                if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                        state_next = ST_STABLE;
                else if (cnt_reg == TIMEOUT_LAST)  do_retry   = 1'b1;
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    do_retry = 1'b1;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 4'd0;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a sleep request and is not counted as a failed attempt.
                if (!lock_s)        state_next = ST_RST_HOLD;
                else if (SLEEP_REQ) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_next = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (!SLEEP_REQ) state_next = ST_WAIT_LOCK;
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_RST_HOLD;
            end
        endcase

        if (do_retry) begin
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RST_HOLD;
        end

        cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
    end

    // Outputs are decoded from the upcoming state so they change on the same edge as STATE.
    always_comb begin
        resetb_next  = 1'b1;
        bypass_next  = 1'b0;
        latch_next   = 1'b0;
        ready_next   = 1'b0;
        sysrstn_next = 1'b0;
        ack_next     = 1'b0;
        fail_next    = 1'b0;
        case (state_next)
            ST_RST_HOLD: begin
                resetb_next = 1'b0;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                resetb_next = 1'b1;
            end
            ST_RUN: begin
                ready_next   = 1'b1;
                sysrstn_next = 1'b1;
            end
            ST_DRAIN: begin
                sysrstn_next = 1'b1;
            end
            ST_SLEEP: begin
                latch_next   = 1'b1;
                ack_next     = 1'b1;
                sysrstn_next = 1'b1;
            end
            ST_FAIL: begin
                resetb_next  = 1'b0;
                bypass_next  = 1'b1;
                fail_next    = 1'b1;
                ready_next   = 1'b1;
                sysrstn_next = 1'b1;
            end
            default: begin
                resetb_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_reg   <= ST_RST_HOLD;
            cnt_reg     <= '0;
            retry_reg   <= 4'd0;
            resetb_reg  <= 1'b0;
            bypass_reg  <= 1'b0;
            latch_reg   <= 1'b0;
            ready_reg   <= 1'b0;
            sysrstn_reg <= 1'b0;
            ack_reg     <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            resetb_reg  <= resetb_next;
            bypass_reg  <= bypass_next;
            latch_reg   <= latch_next;
            ready_reg   <= ready_next;
            sysrstn_reg <= sysrstn_next;
            ack_reg     <= ack_next;
            fail_reg    <= fail_next;
        end
    end

    assign PLL_RESETB = resetb_reg;
    assign PLL_BYPASS = bypass_reg;
    assign PLL_LATCH  = latch_reg;
    assign CLK_READY  = ready_reg;
    assign SYS_RESETN = sysrstn_reg;
    assign SLEEP_ACK  = ack_reg;
    assign FAIL       = fail_reg;
    assign RETRY_CNT  = retry_reg;
    assign STATE      = state_reg;

endmodule
